// File: rtl/pdm_modulator_7bit_if.sv
// Sample handshake and PDM output bundle for pdm_modulator_7bit.
// The master side supplies amplitude samples; the slave side is the modulator.
interface pdm_modulator_7bit_if #(
    parameter int WINDOW_LOG2 = 7
);
    logic [WINDOW_LOG2+1:0] sample_i;
    logic                   sample_valid_i;
    logic                   sample_ready_o;
    logic                   pdm_o;
    logic                   frame_o;
    logic                   underrun_o;
    logic                   busy_o;

    modport master (
        output sample_i,
        output sample_valid_i,
        input  sample_ready_o,
        input  pdm_o,
        input  frame_o,
        input  underrun_o,
        input  busy_o
    );

    modport slave (
        input  sample_i,
        input  sample_valid_i,
        output sample_ready_o,
        output pdm_o,
        output frame_o,
        output underrun_o,
        output busy_o
    );
endinterface

// File: rtl/pdm_modulator_7bit.sv
// First-order sigma-delta PDM transmitter. Samples (0..128) arrive over a
// valid/ready handshake into a one-entry buffer, are swapped in at frame
// boundaries, and each 128-clock frame then carries exactly `sample` ones.
module pdm_modulator_7bit #(
    parameter int WINDOW_LOG2 = 7,
    parameter int IDLE_LEVEL  = 64
) (
    input logic                 M_CLK,
    input logic                 rst_i,
    pdm_modulator_7bit_if.slave bus
);
    localparam int SW    = WINDOW_LOG2 + 2;
    localparam int FRAME = 1 << WINDOW_LOG2;

    localparam logic [SW-1:0]          FULL_SCALE  = SW'(FRAME);
    localparam logic [SW-1:0]          IDLE_ACTIVE = SW'(IDLE_LEVEL);
    localparam logic [WINDOW_LOG2-1:0] CNT_LAST    = '1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [WINDOW_LOG2-1:0] cnt;
    logic [WINDOW_LOG2-1:0] acc;
    logic [WINDOW_LOG2-1:0] acc_next;
    logic [SW-1:0]          pending;
    logic [SW-1:0]          active;
    logic [SW-1:0]          sample_sat;
    logic [SW-1:0]          sum;
    logic                   full;
    logic                   boundary;
    logic                   accept;
    logic                   mod_bit;
    logic                   pdm_q;
    logic                   frame_q;
    logic                   underrun_q;

    // Boundary detection, handshake qualification and input saturation.
    always_comb begin
        boundary   = (cnt == CNT_LAST);
        accept     = bus.sample_valid_i && !full;
        sample_sat = (bus.sample_i > FULL_SCALE) ? FULL_SCALE : bus.sample_i;
    end

    // Sigma-delta step: sum never exceeds 255, so subtracting 128 when the
    // sum reaches 128 leaves exactly the low WINDOW_LOG2 bits as the residue.
    always_comb begin
        sum      = {2'b00, acc} + active;
        mod_bit  = (sum >= FULL_SCALE);
        acc_next = sum[WINDOW_LOG2-1:0];
    end

    // Leave IDLE at the first boundary that has a sample ready to play.
    always_comb begin
        state_next = state;
        if (state == IDLE && boundary && full) begin
            state_next = RUN;
        end
    end

    // State register; RUN is only left through reset.
    always_ff @(posedge M_CLK) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Frame counter, buffer/active swap, modulator and registered outputs.
    always_ff @(posedge M_CLK) begin
        if (rst_i) begin
            cnt        <= '0;
            acc        <= '0;
            pending    <= '0;
            full       <= 1'b0;
            active     <= IDLE_ACTIVE;
            pdm_q      <= 1'b0;
            frame_q    <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            cnt        <= cnt + 1'b1;
            acc        <= acc_next;
            pdm_q      <= mod_bit;
            frame_q    <= boundary;
            underrun_q <= boundary && (state == RUN) && !full;
            if (boundary && full) begin
                active <= pending;
                full   <= 1'b0;
            end
            if (accept) begin
                pending <= sample_sat;
                full    <= 1'b1;
            end
        end
    end

    assign bus.sample_ready_o = !full;
    assign bus.pdm_o          = pdm_q;
    assign bus.frame_o        = frame_q;
    assign bus.underrun_o     = underrun_q;
    assign bus.busy_o         = (state == RUN);
endmodule

// File: tb/tb_pdm_modulator_7bit.sv
// Self-checking bench for pdm_modulator_7bit: a cumulative-density reference
// model predicts every output each cycle, and directed scenarios pin it with
// hand-computed values.
module tb_pdm_modulator_7bit;
    localparam int IDLE_LEVEL = 64;

    logic M_CLK;
    logic rst_i;

    pdm_modulator_7bit_if #(.WINDOW_LOG2(7)) bus ();

    pdm_modulator_7bit #(
        .WINDOW_LOG2(7),
        .IDLE_LEVEL (IDLE_LEVEL)
    ) dut (
        .M_CLK(M_CLK),
        .rst_i(rst_i),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: the number of ones emitted since reset is
    // floor(total density delivered / 128), so each bit is the step in that.
    int modelOk     = 0;
    int mJustReset  = 0;
    int mCnt        = 0;
    int mTotal      = 0;
    int mOldTotal   = 0;
    int mActive     = IDLE_LEVEL;
    int mRun        = 0;
    int mBoundary   = 0;
    int mAccept     = 0;
    int pendQ[$];
    int ePdm = 0, eFrame = 0, eUnder = 0, eBusy = 0, eReady = 1;

    initial begin
        M_CLK = 1'b0;
        forever #5 M_CLK = ~M_CLK;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    always @(posedge M_CLK) begin
        if (rst_i) begin
            modelOk    = 1;
            mJustReset = 1;
            mCnt       = 0;
            mTotal     = 0;
            pendQ.delete();
            mActive    = IDLE_LEVEL;
            mRun       = 0;
            ePdm       = 0;
            eFrame     = 0;
            eUnder     = 0;
        end else if (modelOk != 0) begin
            mJustReset = 0;
            mBoundary  = (mCnt == 127) ? 1 : 0;
            mAccept    = (bus.sample_valid_i && pendQ.size() == 0) ? 1 : 0;
            mOldTotal  = mTotal;
            mTotal     = mTotal + mActive;
            ePdm       = (mTotal / 128) - (mOldTotal / 128);
            eFrame     = mBoundary;
            eUnder     = (mBoundary != 0 && mRun != 0 && pendQ.size() == 0) ? 1 : 0;
            if (mBoundary != 0 && pendQ.size() != 0) begin
                mActive = pendQ.pop_front();
                mRun    = 1;
            end
            if (mAccept != 0) begin
                pendQ.push_back((bus.sample_i > 9'd128) ? 128 : int'(bus.sample_i));
            end
            mCnt = (mCnt + 1) % 128;
        end
        eBusy  = mRun;
        eReady = (pendQ.size() == 0) ? 1 : 0;
    end

    // Per-cycle comparison plus a frame-density check on every full frame.
    int winLen = 0, winOnes = 0, winDensity = IDLE_LEVEL;
    always @(negedge M_CLK) begin
        if (modelOk != 0) begin
            checkOutput("pdm", int'(bus.pdm_o), ePdm);
            checkOutput("frame", int'(bus.frame_o), eFrame);
            checkOutput("underrun", int'(bus.underrun_o), eUnder);
            checkOutput("busy", int'(bus.busy_o), eBusy);
            checkOutput("ready", int'(bus.sample_ready_o), eReady);
            if (mJustReset != 0) begin
                winLen     = 0;
                winOnes    = 0;
                winDensity = mActive;
            end else begin
                winOnes += int'(bus.pdm_o);
                winLen++;
                if (eFrame != 0) begin
                    if (winLen == 128) checkOutput("frameDensity", winOnes, winDensity);
                    winDensity = mActive;
                    winLen     = 0;
                    winOnes    = 0;
                end
            end
        end
    end

    task automatic applyStimulus(input int value, input bit dropAfter);
        int n;
        bus.sample_i       = 9'(value);
        bus.sample_valid_i = 1'b1;
        n = 0;
        while (!bus.sample_ready_o && n < 400) begin
            @(negedge M_CLK);
            n++;
        end
        if (!bus.sample_ready_o) checkOutput("acceptTimeout", 0, 1);
        @(posedge M_CLK);
        @(negedge M_CLK);
        if (dropAfter) bus.sample_valid_i = 1'b0;
    endtask

    task automatic waitFrame();
        int n;
        n = 0;
        do begin
            @(negedge M_CLK);
            n++;
        end while (!bus.frame_o && n < 300);
        if (!bus.frame_o) checkOutput("frameTimeout", 0, 1);
    endtask

    task automatic countFrameOnes(output int ones);
        ones = 0;
        for (int i = 0; i < 128; i++) begin
            @(negedge M_CLK);
            ones += int'(bus.pdm_o);
        end
    endtask

    int idlePattern[4] = '{0, 1, 0, 1};
    int seqIn[4]       = '{0, 128, 200, 1};
    int seqExp[4]      = '{0, 128, 128, 1};
    int ones;
    int n;

    initial begin
        rst_i              = 1'b1;
        bus.sample_i       = '0;
        bus.sample_valid_i = 1'b0;
        repeat (3) @(negedge M_CLK);
        checkOutput("resetReady", int'(bus.sample_ready_o), 1);
        checkOutput("resetBusy", int'(bus.busy_o), 0);
        checkOutput("resetPdm", int'(bus.pdm_o), 0);
        checkOutput("resetFrame", int'(bus.frame_o), 0);
        rst_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge M_CLK);
            checkOutput("idlePattern", int'(bus.pdm_o), idlePattern[i]);
        end
        waitFrame();
        waitFrame();

        // Single sample during IDLE
        applyStimulus(100, 1'b1);
        checkOutput("readyAfterAccept", int'(bus.sample_ready_o), 0);
        waitFrame();
        checkOutput("busyAfterBoundary", int'(bus.busy_o), 1);
        checkOutput("readyAfterBoundary", int'(bus.sample_ready_o), 1);
        countFrameOnes(ones);
        checkOutput("density100", ones, 100);

        // Extremes and saturation, one sample per frame
        for (int i = 0; i < 4; i++) begin
            applyStimulus(seqIn[i], 1'b1);
            waitFrame();
            countFrameOnes(ones);
            checkOutput("seqDensity", ones, seqExp[i]);
        end

        // Underrun: last sample repeats
        applyStimulus(37, 1'b1);
        waitFrame();
        countFrameOnes(ones);
        checkOutput("density37", ones, 37);
        checkOutput("underrunPulse", int'(bus.underrun_o), 1);
        countFrameOnes(ones);
        checkOutput("density37repeat", ones, 37);
        @(negedge M_CLK);
        checkOutput("underrunOneCycle", int'(bus.underrun_o), 0);

        // Valid held high across back-to-back samples
        applyStimulus(10, 1'b0);
        applyStimulus(20, 1'b0);
        applyStimulus(30, 1'b1);
        waitFrame();
        countFrameOnes(ones);
        checkOutput("heldDensity30", ones, 30);

        // Randomized samples and gaps
        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(0, 150)) @(negedge M_CLK);
            applyStimulus(int'($urandom_range(0, 300)), 1'b1);
        end
        waitFrame();
        waitFrame();

        // Reset mid-frame with a pending sample
        waitFrame();
        applyStimulus(55, 1'b1);
        repeat (59) @(negedge M_CLK);
        checkOutput("pendingFullBeforeReset", int'(bus.sample_ready_o), 0);
        rst_i = 1'b1;
        @(negedge M_CLK);
        rst_i = 1'b0;
        checkOutput("midResetReady", int'(bus.sample_ready_o), 1);
        checkOutput("midResetBusy", int'(bus.busy_o), 0);
        checkOutput("midResetPdm", int'(bus.pdm_o), 0);
        checkOutput("midResetUnderrun", int'(bus.underrun_o), 0);
        checkOutput("midResetFrame", int'(bus.frame_o), 0);
        n = 0;
        do begin
            @(negedge M_CLK);
            n++;
        end while (!bus.frame_o && n < 300);
        checkOutput("frameAfterReset", n, 128);
        countFrameOnes(ones);
        checkOutput("densityAfterReset", ones, IDLE_LEVEL);
        checkOutput("busyAfterReset", int'(bus.busy_o), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pdm_modulator_7bit.md
Name: pdm_modulator_7bit

Overview:
- First-order sigma-delta PDM transmitter; the output-side counterpart of the 128-bit-window PDM amplitude receiver (amplituder_7bit).
- Accepts unsigned amplitude samples (0..128) over a valid/ready handshake and emits a 1-bit PDM stream on M_CLK.
- Each 128-clock frame carries exactly `sample` ones.
- Looped back into amplituder_7bit, the receiver's amplitude settles to the transmitted sample.

Parameters:
- WINDOW_LOG2, 7, log2 of frame length (frame = 128 clocks); sample width = WINDOW_LOG2+2 = 9.
- IDLE_LEVEL, 64, density used before the first sample is accepted (midscale = silence).

Ports:
- M_CLK  in  1  PDM bit clock; all logic on posedge.
- rst_i  in  1  synchronous, active-high reset.
- sample_i  in  9  unsigned amplitude; values >128 saturate to 128.
- sample_valid_i  in  1  sample_i valid.
- sample_ready_o  out  1  pending buffer empty; transfer occurs when valid && ready at posedge.
- pdm_o  out  1  registered PDM bit.
- frame_o  out  1  one-cycle pulse: first cycle of a new frame.
- underrun_o  out  1  one-cycle pulse: frame boundary in RUN with no pending sample.
- busy_o  out  1  high in RUN state.

Behaviour:
- Reset values (cycle after rst_i high at posedge):
  - pdm_o=0, frame_o=0, underrun_o=0, busy_o=0, sample_ready_o=1.
  - cnt=0, acc=0, pending empty, active=IDLE_LEVEL, state=IDLE.
- Frame counter cnt (7 bits):
  - Increments every cycle after reset, wraps 127->0.
  - Boundary edge = posedge where cnt==127.
- Pending buffer (1 entry):
  - On accept: pending <= min(sample_i,128), full <= 1.
  - sample_ready_o = !full (combinational from flag).
  - At a boundary edge with full=1: active <= pending, full <= 0.
  - Accept coinciding with a boundary edge while full=0: sample goes to pending and is consumed at the NEXT boundary.
- States:
  - IDLE -> RUN at the first boundary edge with full=1.
  - RUN -> IDLE only via reset.
  - IDLE boundary with empty buffer: no underrun; active stays IDLE_LEVEL.
- Underrun:
  - RUN boundary with full=0: active unchanged (previous sample repeats).
  - underrun_o=1 for the single cycle after that edge.
- frame_o: high exactly in cycles where cnt==0, i.e. the cycle after each boundary edge, including the first wrap after reset.
- Modulator, every edge:
  - sum = acc + active (9 bits).
  - If sum >= 128: pdm_o <= 1, acc <= sum-128. Else: pdm_o <= 0, acc <= sum.
  - acc stays within 0..127 and is NOT cleared at frame boundaries.
- Latency:
  - A sample made active at boundary edge E governs pdm_o after edges E+1..E+128.
  - Those 128 bits contain exactly `sample` ones, independent of the residual acc.
  - Accept-to-first-affected-bit is at most 129 cycles plus the remaining time to the boundary.
- Extremes:
  - active=0: constant 0.
  - active=128: constant 1.
  - active=64 from acc=0: 0,1,0,1,...
- Reset mid-frame: all state returns to reset values; any pending sample is discarded; the next frame starts at cnt=0.

Test Plan:
- Reset, no samples -> sample_ready_o=1, busy_o=0; pdm_o = 0,1,0,1... from acc=0; frame_o every 128 cycles; underrun_o never asserts.
- Send 100 during IDLE -> ready drops the cycle after accept; busy_o rises after the boundary; each following 128-bit frame has exactly 100 ones; ready returns to 1 after the boundary.
- Sequence 0, 128, 200, 1, one per frame -> frame densities 0, 128, 128 (saturated), 1; the frame at 1 shows a single 1.
- Send 37, then no further samples -> underrun_o pulses 1 cycle after each subsequent boundary; density stays 37 ones/frame.
- Valid held high with samples 10, 20, 30 -> 10 accepted; ready low until boundary; 20 accepted after it; frames show 10, 20, 30 in order with no loss or duplication.
- rst_i asserted at cnt=60 while pending full -> all outputs return to reset values next cycle; pending dropped; next frame_o appears 128 cycles after reset release; pdm_o loopback into amplituder_7bit settles to the sent value after 128 cycles of a constant sample.
